bcd_counter_0to19: RTL and testbench
====================================

// Module: bcd_counter_0to19
// PURPOSE
//  Two-digit BCD run/pause counter, 00..MAX_VAL, stepped by an internal prescaler.
//  Sits directly upstream of the 7-segment decoders: tens/ones each drive one 4-bit
//  decoder input. A start/stop key toggles run/pause; clr returns to 00, stopped.
// PARAMETERS
//  TICK_DIV  1000  clk cycles per count step; legal range >= 2
//  MAX_VAL   19    terminal count, decimal; legal range 1..99
// PORTS
//  clk      in   1  single system clock; all state on rising edge
//  rst_n    in   1  asynchronous, active-low reset
//  key      in   1  start/stop key, asynchronous level; acts on its rising edge
//  clr      in   1  synchronous clear, active-high
//  down     in   1  count direction, 1 = down (port exists only with COUNT_DOWN_EN)
//  tens     out  4  BCD tens digit, 0..9
//  ones     out  4  BCD ones digit, 0..9
//  wrap     out  1  one-cycle pulse when count wraps
//  running  out  1  1 while in RUN
// BEHAVIOUR
//  Reset (rst_n=0, any time, including mid-count):
//   - state=IDLE; tens=0, ones=0, wrap=0, running=0
//   - prescaler=0; key synchroniser flops=0
//  Key input path:
//   - two-flop synchroniser s1->s2, then history flop s3
//   - key_edge = s2 & ~s3
//   - key high before edge N changes state at edge N+2
//   - key must stay high >= 1 clk period to be seen
//  FSM:
//   - IDLE --key_edge--> RUN
//   - RUN --key_edge--> PAUSE
//   - PAUSE --key_edge--> RUN
//   - any state --clr--> IDLE: count=00, prescaler=0, wrap=0
//   - clr has priority over key_edge in the same cycle
//  Prescaler:
//   - RUN: increments each clk; at TICK_DIV-1 it reloads 0 and asserts step for that cycle
//   - IDLE/PAUSE: prescaler holds its value, so a resume continues the partial period
//   - first step occurs TICK_DIV clks after entering RUN from IDLE
//  Step, up direction:
//   - ones<9: ones+1
//   - ones==9: ones=0, tens+1
//   - count==MAX_VAL: count becomes 00 and wrap=1
//   - wrap is registered and is high in the same cycle that 00 first appears
//   - wrap is 0 on every other cycle
//  Outputs are registered. tens/ones never exceed 9 and never exceed MAX_VAL as a pair.
//  running mirrors (state==RUN), registered.
// CONFIGURATION
//  COUNT_DOWN_EN defined:
//   - down port present; sampled on each step
//   - down=1: ones>0: ones-1; ones==0: ones=9, tens-1
//   - down=1 from 00: load MAX_VAL (BCD) and pulse wrap
//   - direction change takes effect on the next step; no other effect
//  COUNT_DOWN_EN undefined: no down port; up-count only as above.
// TESTING  (TICK_DIV=4, MAX_VAL=19 unless noted)
//  1. rst_n=0 mid-RUN at 12 -> immediately tens=0, ones=0, wrap=0, running=0.
//     Release -> stays IDLE at 00.
//  2. key high 3 clks from IDLE -> running=1 two edges after first sampling edge.
//     After 40 clks: tens=1, ones=0.
//  3. RUN through 19 -> next step gives tens=0, ones=0 with wrap=1 for exactly 1 clk.
//     Counting continues to 01.
//  4. Key at count 07 with prescaler=2 -> PAUSE, count holds 07 for 50 clks.
//     Key again -> 08 appears 2 clks after running=1.
//  5. clr and key_edge in same cycle while RUN at 15 -> IDLE, 00, running=0, wrap=0.
//  6. COUNT_DOWN_EN, down=1, RUN from 00 -> first step gives 19 with wrap=1.
//     Next step gives 18.

Source files
------------

// File: rtl/bcd_counter_0to19.sv
// ---------------------------------------------------------------------------
// bcd_counter_0to19
//   Two-digit BCD run/pause counter, 00..MAX_VAL, advanced once every TICK_DIV
//   clocks by an internal prescaler while running. The start/stop key toggles
//   IDLE->RUN->PAUSE->RUN...; clr forces IDLE with the count at 00.
//
// Parameters
//   TICK_DIV  clk cycles per count step (>= 2)
//   MAX_VAL   terminal count, decimal (1..99)
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   key      in   start/stop key, asynchronous level, acts on its rising edge
//   clr      in   synchronous clear, active-high, wins over key
//   down     in   count direction, 1 = down (only with COUNT_DOWN_EN)
//   tens     out  BCD tens digit
//   ones     out  BCD ones digit
//   wrap     out  one-cycle pulse in the cycle the wrapped value first appears
//   running  out  high while in RUN
//
// Build option
//   COUNT_DOWN_EN  adds the down port and down-counting; default is up-only.
// ---------------------------------------------------------------------------
module bcd_counter_0to19 #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned MAX_VAL  = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key,
  input  logic       clr,
`ifdef COUNT_DOWN_EN
  input  logic       down,
`endif
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       wrap,
  output logic       running
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0] MAX_TENS = 4'(MAX_VAL / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_VAL % 10);
  localparam logic [3:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_key_s1;
  logic          r_key_s2;
  logic          r_key_s3;
  logic [PW-1:0] r_pre;
  logic [3:0]    r_tens;
  logic [3:0]    r_ones;
  logic          r_wrap;
  logic          r_running;

  logic          w_key_edge;
  logic          w_step;
  logic          w_down;
  logic          w_at_max;
  logic          w_at_zero;
  logic [3:0]    w_nxt_tens;
  logic [3:0]    w_nxt_ones;
  logic          w_nxt_wrap;

`ifdef COUNT_DOWN_EN
  assign w_down = down;
`else
  assign w_down = 1'b0;
`endif

  // Rising edge of the synchronised key; s3 is the history flop.
  assign w_key_edge = r_key_s2 & ~r_key_s3;
  assign w_step     = (r_state == ST_RUN) && (r_pre == PRE_LAST);
  assign w_at_max   = (r_tens == MAX_TENS) && (r_ones == MAX_ONES);
  assign w_at_zero  = (r_tens == 4'd0) && (r_ones == 4'd0);

  // Next BCD value for one count step in the selected direction.
  always_comb begin
    w_nxt_tens = r_tens;
    w_nxt_ones = r_ones;
    w_nxt_wrap = 1'b0;
    if (w_down) begin
      if (w_at_zero) begin
        w_nxt_tens = MAX_TENS;
        w_nxt_ones = MAX_ONES;
        w_nxt_wrap = 1'b1;
      end else if (r_ones == 4'd0) begin
        w_nxt_ones = BCD_NINE;
        w_nxt_tens = r_tens - 4'd1;
      end else begin
        w_nxt_ones = r_ones - 4'd1;
      end
    end else begin
      if (w_at_max) begin
        w_nxt_tens = 4'd0;
        w_nxt_ones = 4'd0;
        w_nxt_wrap = 1'b1;
      end else if (r_ones == BCD_NINE) begin
        w_nxt_ones = 4'd0;
        w_nxt_tens = r_tens + 4'd1;
      end else begin
        w_nxt_ones = r_ones + 4'd1;
      end
    end
  end

  // Key synchroniser, run/pause FSM, prescaler and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_key_s1  <= 1'b0;
      r_key_s2  <= 1'b0;
      r_key_s3  <= 1'b0;
      r_pre     <= '0;
      r_tens    <= 4'd0;
      r_ones    <= 4'd0;
      r_wrap    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_key_s1 <= key;
      r_key_s2 <= r_key_s1;
      r_key_s3 <= r_key_s2;
      if (clr) begin
        r_state   <= ST_IDLE;
        r_pre     <= '0;
        r_tens    <= 4'd0;
        r_ones    <= 4'd0;
        r_wrap    <= 1'b0;
        r_running <= 1'b0;
      end else begin
        r_wrap <= 1'b0;
        // Prescaler only advances in RUN, so a resume finishes the partial period.
        if (r_state == ST_RUN) begin
          if (w_step) begin
            r_pre  <= '0;
            r_tens <= w_nxt_tens;
            r_ones <= w_nxt_ones;
            r_wrap <= w_nxt_wrap;
          end else begin
            r_pre <= r_pre + PW'(1);
          end
        end
        if (w_key_edge) begin
          case (r_state)
            ST_IDLE, ST_PAUSE: begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
            ST_RUN: begin
              r_state   <= ST_PAUSE;
              r_running <= 1'b0;
            end
            default: begin
              r_state   <= ST_IDLE;
              r_running <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign tens    = r_tens;
  assign ones    = r_ones;
  assign wrap    = r_wrap;
  assign running = r_running;

endmodule

// File: tb/tb_bcd_counter_0to19.sv
// ---------------------------------------------------------------------------
// tb_bcd_counter_0to19
//   Scoreboard bench: each stimulus cycle advances a decimal reference model
//   and queues the expected outputs; a monitor pops one entry after every
//   rising edge and compares. Directed scenarios are followed by random ones.
// ---------------------------------------------------------------------------
module tb_bcd_counter_0to19;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned MAX_VAL  = 19;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key = 1'b0;
  logic       clr = 1'b0;
`ifdef COUNT_DOWN_EN
  logic       down = 1'b0;
`endif
  logic [3:0] tens;
  logic [3:0] ones;
  logic       wrap;
  logic       running;

  bcd_counter_0to19 #(
    .TICK_DIV (TICK_DIV),
    .MAX_VAL  (MAX_VAL)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key     (key),
    .clr     (clr),
`ifdef COUNT_DOWN_EN
    .down    (down),
`endif
    .tens    (tens),
    .ones    (ones),
    .wrap    (wrap),
    .running (running)
  );

  always #5 clk = ~clk;

  typedef logic [9:0] exp_t;   // {tens, ones, wrap, running}

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: count as a plain integer, mode 0=idle 1=run 2=pause.
  int   m_cnt;
  int   m_pre;
  int   m_mode;
  bit   m_wrap;
  bit   khist[$];   // key samples of the last three edges, [2] newest

  task automatic chk(input string name, input exp_t got, input exp_t req);
    n_checks++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got tens=%0d ones=%0d wrap=%0b running=%0b, required tens=%0d ones=%0d wrap=%0b running=%0b",
                  name, got[9:6], got[5:2], got[1], got[0], req[9:6], req[5:2], req[1], req[0]);
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_pre  = 0;
    m_mode = 0;
    m_wrap = 1'b0;
    khist.delete();
    repeat (3) khist.push_back(1'b0);
  endtask

  task automatic model_edge(input bit k, input bit c, input bit d);
    bit kedge;
    bit dn;
    bit step;
    kedge = khist[1] && !khist[0];
`ifdef COUNT_DOWN_EN
    dn = d;
`else
    dn = 1'b0;
    if (d) dn = 1'b0;
`endif
    if (c) begin
      m_mode = 0;
      m_cnt  = 0;
      m_pre  = 0;
      m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
      step   = (m_mode == 1) && (m_pre == int'(TICK_DIV) - 1);
      if (m_mode == 1) m_pre = (m_pre + 1) % int'(TICK_DIV);
      if (step) begin
        if (dn) begin
          if (m_cnt == 0) begin m_cnt = int'(MAX_VAL); m_wrap = 1'b1; end
          else m_cnt = m_cnt - 1;
        end else begin
          if (m_cnt == int'(MAX_VAL)) begin m_cnt = 0; m_wrap = 1'b1; end
          else m_cnt = m_cnt + 1;
        end
      end
      if (kedge) m_mode = (m_mode == 1) ? 2 : 1;
    end
    khist.push_back(k);
    void'(khist.pop_front());
  endtask

  // One clock of stimulus; the expectation for the following edge is queued.
  task automatic cycle(input bit k, input bit c, input bit d);
    @(negedge clk);
    key = k;
    clr = c;
`ifdef COUNT_DOWN_EN
    down = d;
`endif
    model_edge(k, c, d);
    exp_q.push_back({4'(m_cnt / 10), 4'(m_cnt % 10), m_wrap, m_mode == 1});
  endtask

  task automatic idle_cycles(input int n, input bit d);
    repeat (n) cycle(1'b0, 1'b0, d);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset(input int hold);
    @(negedge clk);
    key = 1'b0;
    clr = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {tens, ones, wrap, running}, 10'd0);
    model_reset();
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one expectation per rising edge, sampled shortly after it.
  exp_t mon_req;
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_req = exp_q.pop_front();
      chk("out", {tens, ones, wrap, running}, mon_req);
    end
  end

  initial begin
    int guard;
    bit dir;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_state", {tens, ones, wrap, running}, 10'd0);
    rst_n = 1'b1;
    idle_cycles(4, 1'b0);

    // Start with a 3-clock key press, count past 10 and through the wrap.
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(40, 1'b0);
    idle_cycles(60, 1'b0);

    // Reset mid-count, then stay idle.
    async_reset(2);
    idle_cycles(6, 1'b0);

    // Start, pause for 50 clocks, resume.
    cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(30, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(50, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(12, 1'b0);

    // clr in the same cycle as the key edge while running at 15.
    guard = 0;
    while (!(m_cnt == 15 && m_mode == 1) && guard < 400) begin
      cycle(1'b0, 1'b0, 1'b0);
      guard++;
    end
    if (guard >= 400) begin
      n_checks++;
      $display("FAIL reach_15: count=%0d mode=%0d, required count=15 in run", m_cnt, m_mode);
    end
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    idle_cycles(8, 1'b0);

`ifdef COUNT_DOWN_EN
    // Down-count from 00 wraps to MAX_VAL.
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    idle_cycles(30, 1'b1);
    idle_cycles(20, 1'b0);
`endif

    // Random key/clear/direction traffic with occasional resets.
    dir = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) dir = ~dir;
      if ($urandom_range(0, 599) == 0) async_reset($urandom_range(1, 3));
      else cycle($urandom_range(0, 11) == 0, $urandom_range(0, 149) == 0, dir);
    end

    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations pending, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
